hcsr04_scan_scheduler: RTL
==========================

# hcsr04_scan_scheduler

Round-robin scheduler that time-shares a single HC-SR04 ranging driver among up to N ultrasonic sensors. It selects one sensor at a time, fires one measurement, waits for the driver's result or a watchdog expiry, stores the result per channel, then waits a guard gap before the next enabled channel to suppress acoustic crosstalk. It sits between the sensor trig/echo mux (driven by `sel`) and the application logic that reads the per-channel distance registers.

## Interface
- `N_SENSORS`, 4: number of sensor channels, 2..16.
- `TOF_W`, 16: width of the driver's time-of-flight result.
- `GUARD_CYCLES`, 1000: idle cycles after each measurement, ≥1.
- `WDOG_CYCLES`, 60000: maximum cycles to wait for a driver response, ≥2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `scan_en` in 1: level; while high, sweeps repeat continuously.
- `ch_mask` in N_SENSORS: 1 = channel participates; sampled at sweep start.
- `drv_en` out 1: one-cycle measurement request to the driver.
- `drv_data_ready` in 1: driver success pulse.
- `drv_timeout_err` in 1: driver echo-timeout pulse.
- `drv_tof` in TOF_W: driver result, valid with `drv_data_ready`.
- `sel` out max(1,$clog2(N_SENSORS)): active channel index for the trig/echo mux.
- `tof_out` out N_SENSORS*TOF_W: packed per-channel results; channel k at bits [k*TOF_W +: TOF_W].
- `tof_valid` out N_SENSORS: channel holds a fresh good result from its latest measurement.
- `tof_err` out N_SENSORS: the channel's latest measurement failed (driver timeout or watchdog).
- `busy` out 1: high in any state except IDLE.
- `sweep_done` out 1: one-cycle pulse when a sweep completes.

## Operation
- FSM states: IDLE, ARM, WAIT_RES, GUARD, NEXT.
- IDLE:
  - If `scan_en`=1 and `ch_mask`≠0: latch `ch_mask` into `mask_q`, set `sel` to the lowest set bit, go to ARM.
  - If `ch_mask`=0: remain in IDLE; `busy` stays 0.
- ARM: assert `drv_en` for exactly one cycle, clear the watchdog counter, go to WAIT_RES.
- WAIT_RES (watchdog counter increments every cycle); priority order:
  1. `drv_timeout_err`=1: set `tof_err[sel]`=1, clear `tof_valid[sel]`, keep `tof_out[sel]`. Go to GUARD. This applies even if `drv_data_ready`=1 in the same cycle.
  2. `drv_data_ready`=1: store `tof_out[sel]`=`drv_tof`, set `tof_valid[sel]`=1, clear `tof_err[sel]`. Go to GUARD.
  3. Watchdog counter reaches WDOG_CYCLES-1 with no response: handle as a timeout. A driver response in that same cycle wins over the watchdog.
- GUARD: count GUARD_CYCLES cycles, then go to NEXT.
- NEXT:
  - Another higher set bit remains in `mask_q`: move `sel` to it and go to ARM.
  - Otherwise the sweep is complete: pulse `sweep_done`. Then:
    - `scan_en`=1: reload `mask_q` from `ch_mask` (IDLE rules apply to a zero mask) and go to ARM at the lowest set bit.
    - `scan_en`=0: go to IDLE.
- `scan_en` falling mid-sweep: the current channel completes normally, including its GUARD period. NEXT then returns to IDLE with no `sweep_done` pulse. Unvisited channels keep their old values.
- `ch_mask` changes mid-sweep are ignored until the next sweep.
- Counters are sized with $clog2 of their terminal counts. Channel advance never wraps inside a sweep.

## Timing
- Reset values (asynchronous): state=IDLE; `drv_en`=0, `sel`=0, `tof_out`=0, `tof_valid`=0, `tof_err`=0, `busy`=0, `sweep_done`=0; all counters 0.
- Reset asserted mid-measurement aborts immediately. The driver is responsible for its own reset.
- Cycle 0 = IDLE sees `scan_en`. `drv_en` is high in cycle 1. `sel` is stable from cycle 1 until the NEXT cycle.
- Result registers update on the edge after the driver pulse. `tof_out` and `tof_valid` change together.
- Per-channel period = 1 (ARM) + response latency + 1 + GUARD_CYCLES + 1 (NEXT).
- `sweep_done` is high for exactly one cycle, in the cycle after the final NEXT decision.
- Driver pulses outside WAIT_RES are ignored.

## Test plan
- N=4, mask=4'b1111, `scan_en` held high, driver model returns tof=100+k for channel k after 200 cycles:
  - `sel` runs 0,1,2,3; `tof_out` = {103,102,101,100}; `tof_valid`=4'b1111.
  - `sweep_done` pulses once, then the sweep restarts at channel 0.
- mask=4'b1010: only channels 1 and 3 are measured; `tof_valid[0]` and `tof_valid[2]` stay 0; spacing between the two `drv_en` pulses ≥ GUARD_CYCLES+3.
- Channel 2 driver never responds, WDOG_CYCLES=500:
  - `tof_err[2]`=1 exactly 500 cycles after its `drv_en`; `tof_valid[2]`=0 and old `tof_out[2]` retained.
  - The scheduler advances to channel 3.
- `drv_data_ready` and `drv_timeout_err` in the same cycle: `tof_err`=1, `tof_valid`=0, `tof_out` unchanged.
- `scan_en` dropped while channel 1 is in WAIT_RES: channel 1 completes, state returns to IDLE, `busy`=0, no `sweep_done` pulse.
- `rst` pulsed during GUARD: all outputs are 0 within the same cycle; after release with `scan_en`=1, measurement restarts at channel 0.

Source files
------------

// File: rtl/hcsr04_scan_scheduler.sv
// Round-robin scheduler that time-shares one HC-SR04 ranging driver among N_SENSORS channels,
// keeping per-channel results, a response watchdog and a crosstalk guard gap between channels.
module hcsr04_scan_scheduler #(
    parameter int unsigned N_SENSORS    = 4,
    parameter int unsigned TOF_W        = 16,
    parameter int unsigned GUARD_CYCLES = 1000,
    parameter int unsigned WDOG_CYCLES  = 60000,
    localparam int unsigned SEL_W       = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scan_en,
    input  logic [N_SENSORS-1:0]       ch_mask,
    output logic                       drv_en,
    input  logic                       drv_data_ready,
    input  logic                       drv_timeout_err,
    input  logic [TOF_W-1:0]           drv_tof,
    output logic [SEL_W-1:0]           sel,
    output logic [N_SENSORS*TOF_W-1:0] tof_out,
    output logic [N_SENSORS-1:0]       tof_valid,
    output logic [N_SENSORS-1:0]       tof_err,
    output logic                       busy,
    output logic                       sweep_done
);

    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int unsigned GD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StArm, StWaitRes, StGuard, StNext} state_e;

    state_e                     state_q, state_d;
    logic [N_SENSORS-1:0]       mask_q, mask_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [WD_W-1:0]            wdog_q, wdog_d;
    logic [GD_W-1:0]            guard_q, guard_d;
    logic [N_SENSORS*TOF_W-1:0] tof_q, tof_d;
    logic [N_SENSORS-1:0]       valid_q, valid_d;
    logic [N_SENSORS-1:0]       err_q, err_d;
    logic                       done_q, done_d;

    logic [SEL_W-1:0]           first_idx, next_idx;
    logic                       has_next;

    // Lowest set bit of the live mask, used when a sweep (re)starts.
    always_comb begin
        first_idx = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_idx = SEL_W'(i);
        end
    end

    // Lowest latched channel strictly above the current one; never wraps.
    always_comb begin
        has_next = 1'b0;
        next_idx = sel_q;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                has_next = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        guard_d = guard_q;
        tof_d   = tof_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (scan_en && (|ch_mask)) begin
                    mask_d  = ch_mask;
                    sel_d   = first_idx;
                    state_d = StArm;
                end
            end
            StArm: begin
                wdog_d  = '0;
                state_d = StWaitRes;
            end
            StWaitRes: begin
                wdog_d = wdog_q + WD_W'(1);
                // A driver timeout beats a same-cycle success; any response beats the watchdog.
                if (drv_timeout_err ||
                    (!drv_data_ready && (wdog_q == WD_W'(WDOG_CYCLES - 1)))) begin
                    err_d[sel_q]   = 1'b1;
                    valid_d[sel_q] = 1'b0;
                    guard_d        = '0;
                    state_d        = StGuard;
                end else if (drv_data_ready) begin
                    tof_d[int'(sel_q)*TOF_W +: TOF_W] = drv_tof;
                    valid_d[sel_q] = 1'b1;
                    err_d[sel_q]   = 1'b0;
                    guard_d        = '0;
                    state_d        = StGuard;
                end
            end
            StGuard: begin
                if (guard_q == GD_W'(GUARD_CYCLES - 1)) begin
                    state_d = StNext;
                end else begin
                    guard_d = guard_q + GD_W'(1);
                end
            end
            StNext: begin
                if (has_next) begin
                    if (scan_en) begin
                        sel_d   = next_idx;
                        state_d = StArm;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    done_d = 1'b1;
                    if (scan_en && (|ch_mask)) begin
                        mask_d  = ch_mask;
                        sel_d   = first_idx;
                        state_d = StArm;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            sel_q   <= '0;
            wdog_q  <= '0;
            guard_q <= '0;
            tof_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            wdog_q  <= wdog_d;
            guard_q <= guard_d;
            tof_q   <= tof_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign drv_en     = (state_q == StArm);
    assign busy       = (state_q != StIdle);
    assign sel        = sel_q;
    assign tof_out    = tof_q;
    assign tof_valid  = valid_q;
    assign tof_err    = err_q;
    assign sweep_done = done_q;

endmodule
